sqrt_arbiter: RTL and testbench
===============================

Name: sqrt_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative square-root engine (square_root) among NREQ requesters in the calculator datapath.
- Accepts one request at a time and latches its operand.
- Drives the engine's state/opcode strobe for exactly N/2 cycles, captures the root, and returns it to the granted requester with a valid/ack handshake.

Parameters:
- N, `INPUTWIDTH (16 in tests), operand width; root width N/2; N even, N>=4.
- NREQ, 4, number of requesters; NREQ>=2.

Ports:
- Clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until gnt.
- req_data  in  NREQ*N  operands; requester i occupies bits [i*N +: N].
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted.
- resp_valid  out  NREQ  one-hot; result for that requester; held until ack.
- resp_root  out  N/2  square root; valid while resp_valid != 0.
- resp_err  out  1  watchdog error qualifier (optional feature); else 0.
- resp_ack  in  NREQ  requester consumes result.
- busy  out  1  high in every state except IDLE.
- eng_reset  out  1  engine reset = reset OR abort pulse.
- eng_state  out  3  to engine state; `EXECB while issuing, else 0.
- eng_opcode  out  4  to engine opcode; `SQRT while issuing, else 0.
- eng_num  out  N  operand to engine num_in.
- eng_done  in  1  engine done.
- eng_root  in  N/2  engine sq_root.

Behaviour:
- Reset values: gnt=0, resp_valid=0, resp_root=0, resp_err=0, eng_state=0, eng_opcode=0, eng_num=0, state=IDLE, rr pointer=0, cycle count=0.
- All outputs are registered except eng_reset and busy.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr pointer, wrapping modulo NREQ.
  - At that edge: gnt[w]<=1 for one cycle; eng_num<=req_data[w]; owner<=w; eng_state<=`EXECB; eng_opcode<=`SQRT; count<=1; go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - Engine strobe is high for exactly N/2 clock edges.
  - Each edge increments count.
  - On the edge where count==N/2: drive eng_state/eng_opcode to 0 and go to CAPTURE.
  - The strobe must never stay asserted for N/2+1 edges; that would restart the engine.
- CAPTURE, one cycle:
  - resp_root<=eng_root; resp_valid[owner]<=1; rr pointer<=(owner+1) mod NREQ; go to RESP.
  - eng_done is stale-high from the prior op until the engine's first active edge, so it is only meaningful here.
- RESP:
  - Hold resp_valid and resp_root.
  - On an edge with resp_ack[owner]=1: clear resp_valid and resp_err, go to IDLE.
  - Ack bits of non-owners are ignored.
  - No new grant is issued on the ack edge.
- Latency: resp_valid rises N/2+1 cycles after the gnt edge (N=16: 9 cycles). Minimum request-to-request spacing is N/2+3 cycles.
- Requests arriving while busy stay pending; arbitration is evaluated only in IDLE.
- Owner with req still high after ack may win again only if no other requester is pending (rr fairness).
- A request dropped before grant is never granted.
- Reset at any point (including mid-ISSUE):
  - Returns to IDLE with reset values.
  - eng_reset is high that cycle; the pending result is discarded and no resp_valid is emitted.

Optional Feature:
- Macro: SQRT_ARB_WDOG_EN.
- Enabled, in CAPTURE:
  - eng_done==0: resp_err<=1, resp_root<=0, and eng_reset pulses high for one cycle to re-sync the engine. resp_valid[owner] is still raised, so the requester always gets a response.
  - eng_done==1: resp_err<=0.
- Disabled: CAPTURE ignores eng_done; resp_err is tied 0; eng_reset = reset.

Test Plan (N=16, NREQ=4, real square_root engine unless stated):
- req[0]=1, data=144 -> gnt[0] pulse; resp_valid[0] 9 cycles later, resp_root=12; ack -> resp_valid=0, busy=0 next cycle.
- Sequential single requests with data 0, 1, 65535, 2 -> roots 0, 1, 255, 1.
- req=4'b1111 held, ack each result immediately -> grant order 0,1,2,3,0; eng_state=`EXECB for exactly 8 cycles per op.
- req[2] with data 100 in RESP; ack on resp_ack[1] only -> no state change; then ack[2] -> IDLE.
- Reset asserted 3 cycles into ISSUE -> next cycle IDLE, all outputs 0, eng_reset=1 that cycle; a new request with data 81 then yields 9.
- SQRT_ARB_WDOG_EN defined, bench engine model holds eng_done=0 -> resp_valid[owner]=1, resp_err=1, resp_root=0, eng_reset one-cycle pulse.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin sharing of one iterative square-root engine among NREQ requesters.
// Optional engine-done watchdog at capture is enabled by defining SQRT_ARB_WDOG_EN.
`ifndef INPUTWIDTH
`define INPUTWIDTH 16
`endif
`ifndef EXECB
`define EXECB 3'b100
`endif
`ifndef SQRT
`define SQRT 4'b1010
`endif

// state   | meaning
// IDLE    | waiting for a request; arbitration happens only here
// ISSUE   | engine strobe asserted, counting N/2 edges
// CAPTURE | strobe dropped; latch engine root and raise resp_valid
// RESP    | holding result until the owner acks
module sqrt_arbiter #(
  parameter int N    = `INPUTWIDTH,
  parameter int NREQ = 4
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   resp_valid,
  output logic [N/2-1:0]    resp_root,
  output logic              resp_err,
  input  logic [NREQ-1:0]   resp_ack,
  output logic              busy,
  output logic              eng_reset,
  output logic [2:0]        eng_state,
  output logic [3:0]        eng_opcode,
  output logic [N-1:0]      eng_num,
  input  logic              eng_done,
  input  logic [N/2-1:0]    eng_root
);

  localparam int HALF = N / 2;
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(HALF + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]      state;
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   owner;
  logic [CW-1:0]   count;
  logic [NREQ-1:0] req_rot;
  logic [OW-1:0]   off;
  logic [OW:0]     win_sum;
  logic [OW-1:0]   winner;
  logic [OW-1:0]   owner_next;

  // Rotate so the rr pointer sits at bit 0; the lowest set bit is then the winner offset.
  assign req_rot = NREQ'({req, req} >> rr_ptr);

  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = OW'(k);
    end
  end

  assign win_sum    = {1'b0, rr_ptr} + {1'b0, off};
  assign winner     = (win_sum >= (OW+1)'(NREQ)) ? OW'(win_sum - (OW+1)'(NREQ))
                                                 : win_sum[OW-1:0];
  assign owner_next = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;

  assign busy = (state != IDLE);

`ifdef SQRT_ARB_WDOG_EN
  logic wdog_pulse;
  assign eng_reset = reset | wdog_pulse;
`else
  logic unused_done;
  assign unused_done = eng_done;
  assign eng_reset   = reset;
  assign resp_err    = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      count      <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_root  <= '0;
      eng_state  <= '0;
      eng_opcode <= '0;
      eng_num    <= '0;
`ifdef SQRT_ARB_WDOG_EN
      resp_err   <= 1'b0;
      wdog_pulse <= 1'b0;
`endif
    end else begin
      gnt <= '0;
`ifdef SQRT_ARB_WDOG_EN
      wdog_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            gnt        <= NREQ'(1) << winner;
            eng_num    <= req_data[winner*N +: N];
            owner      <= winner;
            eng_state  <= `EXECB;
            eng_opcode <= `SQRT;
            count      <= CW'(1);
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          count <= count + 1'b1;
          // One more strobe edge would restart the engine.
          if (count == CW'(HALF)) begin
            eng_state  <= '0;
            eng_opcode <= '0;
            state      <= CAPTURE;
          end
        end
        CAPTURE: begin
          resp_valid <= NREQ'(1) << owner;
          rr_ptr     <= owner_next;
          state      <= RESP;
`ifdef SQRT_ARB_WDOG_EN
          if (eng_done) begin
            resp_root <= eng_root;
            resp_err  <= 1'b0;
          end else begin
            resp_root  <= '0;
            resp_err   <= 1'b1;
            wdog_pulse <= 1'b1;
          end
`else
          resp_root <= eng_root;
`endif
        end
        RESP: begin
          if (resp_ack[owner]) begin
            resp_valid <= '0;
`ifdef SQRT_ARB_WDOG_EN
            resp_err   <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: random and directed stimulus against a transaction-timeline model,
// with a behavioural square-root engine standing in for the real one.
`ifndef INPUTWIDTH
`define INPUTWIDTH 16
`endif
`ifndef EXECB
`define EXECB 3'b100
`endif
`ifndef SQRT
`define SQRT 4'b1010
`endif

module tb_sqrt_arbiter;
  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int HALF = N / 2;
`ifdef SQRT_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic              Clock;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   resp_valid;
  logic [HALF-1:0]   resp_root;
  logic              resp_err;
  logic [NREQ-1:0]   resp_ack;
  logic              busy;
  logic              eng_reset;
  logic [2:0]        eng_state;
  logic [3:0]        eng_opcode;
  logic [N-1:0]      eng_num;
  logic              eng_done;
  logic [HALF-1:0]   eng_root;

  sqrt_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .Clock(Clock), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .resp_valid(resp_valid), .resp_root(resp_root), .resp_err(resp_err),
    .resp_ack(resp_ack), .busy(busy), .eng_reset(eng_reset), .eng_state(eng_state),
    .eng_opcode(eng_opcode), .eng_num(eng_num), .eng_done(eng_done), .eng_root(eng_root)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  function automatic logic [HALF-1:0] isqrt(input logic [N-1:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return r[HALF-1:0];
  endfunction

  // Engine stand-in: result and done appear after N/2 strobe edges; stall withholds done.
  logic stall;
  int   e_cnt;
  always @(posedge Clock) begin
    if (eng_reset) begin
      e_cnt    <= 0;
      eng_done <= 1'b0;
      eng_root <= '0;
    end else if (eng_state == `EXECB && eng_opcode == `SQRT) begin
      e_cnt <= e_cnt + 1;
      if (e_cnt == 0) eng_done <= 1'b0;
      if (e_cnt == HALF - 1) begin
        eng_root <= stall ? 8'h5a : isqrt(eng_num);
        eng_done <= !stall;
      end
    end else begin
      e_cnt <= 0;
    end
  end

  // Model: time since grant drives every expected output.
  bit              m_idle = 1'b1;
  int              m_t = 0, m_owner = 0, m_rr = 0;
  logic [NREQ-1:0] e_gnt = '0, e_valid = '0;
  logic [HALF-1:0] e_root = '0;
  logic [N-1:0]    e_num = '0;
  logic            e_err = 1'b0, e_strobe = 1'b0, e_pulse = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit found;
    if (reset) begin
      m_idle = 1'b1; m_t = 0; m_rr = 0;
      e_gnt = '0; e_valid = '0; e_root = '0; e_num = '0;
      e_err = 1'b0; e_strobe = 1'b0; e_pulse = 1'b0;
      return;
    end
    e_gnt   = '0;
    e_pulse = 1'b0;
    if (m_idle) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_rr + k) % NREQ;
        if (!found && req[c]) begin
          found = 1'b1;
          m_owner = c;
        end
      end
      if (found) begin
        e_gnt    = NREQ'(1 << m_owner);
        e_num    = req_data[m_owner*N +: N];
        e_strobe = 1'b1;
        m_t      = 0;
        m_idle   = 1'b0;
      end
    end else begin
      m_t++;
      if (m_t == HALF) e_strobe = 1'b0;
      if (m_t == HALF + 1) begin
        e_valid = NREQ'(1 << m_owner);
        m_rr    = (m_owner + 1) % NREQ;
        if (WDOG && stall) begin
          e_root = '0; e_err = 1'b1; e_pulse = 1'b1;
        end else begin
          e_root = isqrt(e_num); e_err = 1'b0;
        end
      end else if (m_t > HALF + 1 && resp_ack[m_owner]) begin
        e_valid = '0;
        e_err   = 1'b0;
        m_idle  = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("gnt", gnt, e_gnt);
    chk("resp_valid", resp_valid, e_valid);
    chk("resp_err", resp_err, e_err);
    chk("busy", busy, !m_idle);
    chk("eng_state", eng_state, e_strobe ? `EXECB : 3'd0);
    chk("eng_opcode", eng_opcode, e_strobe ? `SQRT : 4'd0);
    chk("eng_num", eng_num, e_num);
    chk("eng_reset", eng_reset, reset | e_pulse);
    if (e_valid != '0) chk("resp_root", resp_root, e_root);
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; resp_ack = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    reset = 1'b0; req = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      resp_ack = resp_valid;
      tick();
      done = !busy;
    end
    resp_ack = '0;
    chk("drain_idle", done, 1);
  endtask

  task automatic serve(input int idx, input logic [N-1:0] d, input int exp_root);
    bit seen;
    int lat;
    req_data[idx*N +: N] = d;
    req[idx] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      seen = gnt[idx];
    end
    chk("serve_gnt", seen, 1);
    req[idx] = 1'b0;
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      lat++;
      seen = resp_valid[idx];
    end
    chk("serve_latency", lat, 9);
    chk("serve_root", resp_root, exp_root);
    resp_ack[idx] = 1'b1;
    tick();
    resp_ack[idx] = 1'b0;
    chk("serve_ack_valid", resp_valid, 0);
    chk("serve_ack_busy", busy, 0);
  endtask

  initial begin
    int order [5];
    int exp_order [5];
    int nq, run;
    bit seen;
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = '0; req_data = '0; resp_ack = '0; stall = 1'b0;
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_root", resp_root, 0);
    chk("rst_num", eng_num, 0);
    chk("rst_eng_reset", eng_reset, 1);
    reset = 1'b0;
    tick();

    serve(0, 16'd144, 12);
    serve(1, 16'd0, 0);
    serve(2, 16'd1, 1);
    serve(3, 16'd65535, 255);
    serve(0, 16'd2, 1);

    // All four held, immediate acks: rotating grants and an 8-edge strobe per op.
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = 16'($urandom);
    req = 4'hF;
    nq = 0; run = 0;
    for (int c = 0; c < 200 && nq < 5; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (gnt[i]) begin order[nq] = i; nq++; end
      if (eng_state == `EXECB) run++;
      else if (run != 0) begin
        chk("strobe_len", run, 8);
        run = 0;
      end
      resp_ack = resp_valid;
    end
    chk("rr_grants", nq, 5);
    for (int i = 0; i < 5; i++) chk("rr_order", order[i], exp_order[i]);
    drain();

    // Non-owner ack is ignored while the result is held.
    do_reset();
    req_data[2*N +: N] = 16'd100;
    req[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin tick(); seen = resp_valid[2]; if (gnt[2]) req[2] = 1'b0; end
    req = '0;
    chk("nonowner_seen", seen, 1);
    chk("nonowner_root", resp_root, 10);
    resp_ack = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("nonowner_hold", resp_valid, 4'b0100);
      chk("nonowner_busy", busy, 1);
    end
    resp_ack = 4'b0100;
    tick();
    resp_ack = '0;
    chk("owner_ack_valid", resp_valid, 0);
    chk("owner_ack_busy", busy, 0);

    // Reset in the middle of ISSUE discards the operation.
    req_data[0 +: N] = 16'd400;
    req[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin tick(); seen = gnt[0]; end
    req = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("midrst_state", eng_state, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_num", eng_num, 0);
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_eng_reset", eng_reset, 1);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    serve(1, 16'd81, 9);

    // Randomized traffic with sporadic resets, drops and stray acks.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (gnt[i] || $urandom_range(0, 39) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          req_data[i*N +: N] = 16'($urandom);
        end
      end
      resp_ack = 4'($urandom_range(0, 15));
    end
    drain();

`ifdef SQRT_ARB_WDOG_EN
    stall = 1'b1;
    req_data[3*N +: N] = 16'd49;
    req[3] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin tick(); seen = resp_valid[3]; if (gnt[3]) req[3] = 1'b0; end
    req = '0;
    chk("wdog_seen", seen, 1);
    chk("wdog_err", resp_err, 1);
    chk("wdog_root", resp_root, 0);
    chk("wdog_pulse", eng_reset, 1);
    tick();
    chk("wdog_pulse_end", eng_reset, 0);
    resp_ack[3] = 1'b1;
    tick();
    resp_ack = '0;
    chk("wdog_err_clr", resp_err, 0);
    stall = 1'b0;
    serve(3, 16'd49, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
